deserializer_framed: RTL and testbench

Parametrised, frame-aligned serial-to-parallel converter with a valid/ready output handshake. A serial bit stream, gated by a per-bit valid strobe, is assembled into DATA_WIDTH-bit words in either bit order. Each completed word is presented on a held output register, and the block flags overrun and resynchronisation events. It sits on the receive side of serial links and feeds downstream parallel logic that may stall.

---
 rtl/deserializer_framed.sv | 94 +++++++++
 tb/tb_deserializer_framed.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer_framed.sv
// Frame-aligned serial-to-parallel converter with a held valid/ready output word.
// Flags dropped words (overrun) and mid-word realignment (frame_error).
module deserializer_framed #(
    parameter int DATA_WIDTH = 8,
    parameter int MSB_FIRST  = 0,
    parameter int CONTINUOUS = 0
) (
    input  logic                                  clock_in,
    input  logic                                  reset,
    input  logic                                  serial_valid,
    input  logic                                  serial_in,
    input  logic                                  frame_start,
    output logic [DATA_WIDTH-1:0]                 data_out,
    output logic                                  data_valid,
    input  logic                                  data_ready,
    output logic                                  overrun,
    output logic                                  frame_error,
    output logic [$clog2(DATA_WIDTH+1)-1:0]       bit_count
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  shift_reg;

    logic                   accept_bit;
    logic                   start_word;
    logic                   resync;
    logic                   word_done;
    logic [DATA_WIDTH-1:0]  next_shift;

    function automatic logic [DATA_WIDTH-1:0] shift_in(
        input logic [DATA_WIDTH-1:0] cur,
        input logic                  bit_in
    );
        if (MSB_FIRST != 0) begin
            return {cur[DATA_WIDTH-2:0], bit_in};
        end else begin
            return {bit_in, cur[DATA_WIDTH-1:1]};
        end
    endfunction

    // A fresh word starts from an empty register so stale bits never leak into it.
    always_comb begin
        accept_bit = serial_valid && ((state == SHIFT) || frame_start);
        start_word = accept_bit && ((bit_count == '0) || frame_start);
        resync     = serial_valid && frame_start && (state == SHIFT) && (bit_count != '0);
        next_shift = shift_in(start_word ? '0 : shift_reg, serial_in);
        word_done  = accept_bit && !start_word && (bit_count == LAST_BIT);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_count   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            overrun     <= 1'b0;
            frame_error <= resync;

            if (accept_bit) begin
                shift_reg <= next_shift;
                if (word_done) begin
                    bit_count <= '0;
                    state     <= (CONTINUOUS != 0) ? SHIFT : IDLE;
                end else begin
                    bit_count <= start_word ? CNT_W'(1) : bit_count + CNT_W'(1);
                    state     <= SHIFT;
                end
            end

            // Output word: load when empty or draining this cycle, otherwise drop.
            if (word_done && (!data_valid || data_ready)) begin
                data_out   <= next_shift;
                data_valid <= 1'b1;
            end else if (word_done) begin
                overrun    <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer_framed.sv
// Bench for deserializer_framed: LSB-first, MSB-first and continuous instances share one stimulus.
module tb_deserializer_framed;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic clock_in     = 1'b0;
    logic reset        = 1'b1;
    logic serial_valid = 1'b0;
    logic serial_in    = 1'b0;
    logic frame_start  = 1'b0;
    logic data_ready   = 1'b0;

    logic [W-1:0]  dout [3];
    logic          dv   [3];
    logic          ovr  [3];
    logic          fe   [3];
    logic [CW-1:0] bc   [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];

    typedef struct packed {
        logic [W-1:0] seq;
        logic [W-1:0] lsb;
        logic [W-1:0] msb;
    } vec_t;

    vec_t vecs [7];

    always #5 clock_in = ~clock_in;

    deserializer_framed #(.DATA_WIDTH(W), .MSB_FIRST(0), .CONTINUOUS(0)) u_lsb (
        .clock_in(clock_in), .reset(reset), .serial_valid(serial_valid),
        .serial_in(serial_in), .frame_start(frame_start), .data_out(dout[0]),
        .data_valid(dv[0]), .data_ready(data_ready), .overrun(ovr[0]),
        .frame_error(fe[0]), .bit_count(bc[0])
    );

    deserializer_framed #(.DATA_WIDTH(W), .MSB_FIRST(1), .CONTINUOUS(0)) u_msb (
        .clock_in(clock_in), .reset(reset), .serial_valid(serial_valid),
        .serial_in(serial_in), .frame_start(frame_start), .data_out(dout[1]),
        .data_valid(dv[1]), .data_ready(data_ready), .overrun(ovr[1]),
        .frame_error(fe[1]), .bit_count(bc[1])
    );

    deserializer_framed #(.DATA_WIDTH(W), .MSB_FIRST(0), .CONTINUOUS(1)) u_cont (
        .clock_in(clock_in), .reset(reset), .serial_valid(serial_valid),
        .serial_in(serial_in), .frame_start(frame_start), .data_out(dout[2]),
        .data_valid(dv[2]), .data_ready(data_ready), .overrun(ovr[2]),
        .frame_error(fe[2]), .bit_count(bc[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] mask, input logic [W-1:0] e0,
                        input logic [W-1:0] e1, input logic [W-1:0] e2);
        if (mask[0]) q0.push_back(e0);
        if (mask[1]) q1.push_back(e1);
        if (mask[2]) q2.push_back(e2);
    endtask

    task automatic pop_check(input int i);
        int           sz;
        logic [W-1:0] e;
        case (i)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected[%0d]: got word %0h, expected no word", i, dout[i]);
        end else begin
            case (i)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("sb_word[%0d]", i), 32'(dout[i]), 32'(e));
        end
    endtask

    // Every handshake consumes one word; compare it against the scoreboard.
    always @(negedge clock_in) begin
        if (reset === 1'b0) begin
            for (int i = 0; i < 3; i++) begin
                if (dv[i] === 1'b1 && data_ready === 1'b1) pop_check(i);
            end
        end
    end

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic drive(input logic sv, input logic b, input logic fs);
        serial_valid = sv;
        serial_in    = b;
        frame_start  = fs;
        tick();
    endtask

    task automatic send_word(input logic [W-1:0] seq, input bit framed, input int gap);
        for (int k = 0; k < W; k++) begin
            drive(1'b1, seq[k], framed && (k == 0));
            if (k != W - 1) begin
                for (int g = 0; g < gap; g++) begin
                    drive(1'b0, ~seq[k], 1'b1);
                    chk("gap_bit_count", 32'(bc[0]), 32'(k + 1));
                    chk("gap_frame_error", 32'(fe[0]), 32'd0);
                end
            end
        end
    endtask

    task automatic chk_reset_state();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_data_out[%0d]", i),    32'(dout[i]), 32'd0);
            chk($sformatf("rst_data_valid[%0d]", i),  32'(dv[i]),   32'd0);
            chk($sformatf("rst_bit_count[%0d]", i),   32'(bc[i]),   32'd0);
            chk($sformatf("rst_overrun[%0d]", i),     32'(ovr[i]),  32'd0);
            chk($sformatf("rst_frame_error[%0d]", i), 32'(fe[i]),   32'd0);
        end
    endtask

    logic [W-1:0] w3c;
    logic [W-1:0] w5a;
    logic [W-1:0] wf0;

    initial begin
        vecs[0] = '{seq: 8'h4D, lsb: 8'h4D, msb: 8'hB2};
        vecs[1] = '{seq: 8'h01, lsb: 8'h01, msb: 8'h80};
        vecs[2] = '{seq: 8'hF0, lsb: 8'hF0, msb: 8'h0F};
        vecs[3] = '{seq: 8'hC8, lsb: 8'hC8, msb: 8'h13};
        vecs[4] = '{seq: 8'hFF, lsb: 8'hFF, msb: 8'hFF};
        vecs[5] = '{seq: 8'h00, lsb: 8'h00, msb: 8'h00};
        vecs[6] = '{seq: 8'h81, lsb: 8'h81, msb: 8'h81};
        w3c = 8'h3C;
        w5a = 8'h5A;
        wf0 = 8'hF0;

        reset = 1'b1;
        tick();
        tick();
        chk_reset_state();
        reset = 1'b0;

        // Framed words in both bit orders, consumer always ready.
        data_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            push(3'b111, vecs[v].lsb, vecs[v].msb, vecs[v].lsb);
            send_word(vecs[v].seq, 1'b1, 0);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("vec%0d_valid[%0d]", v, i), 32'(dv[i]), 32'd1);
                chk($sformatf("vec%0d_bit_count[%0d]", v, i), 32'(bc[i]), 32'd0);
            end
            drive(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++)
                chk($sformatf("vec%0d_valid_drop[%0d]", v, i), 32'(dv[i]), 32'd0);
        end

        // Gaps of three idle cycles between bits, frame_start toggled while idle.
        push(3'b111, 8'h4D, 8'hB2, 8'h4D);
        send_word(8'h4D, 1'b1, 3);
        chk("gap_valid", 32'(dv[0]), 32'd1);
        drive(1'b0, 1'b0, 1'b0);
        chk("gap_valid_drop", 32'(dv[0]), 32'd0);

        // Backpressure: second word on the continuous instance is dropped.
        data_ready = 1'b0;
        push(3'b111, 8'hA5, 8'hA5, 8'hA5);
        send_word(8'hA5, 1'b1, 0);
        for (int k = 0; k < W; k++) begin
            drive(1'b1, w3c[k], 1'b0);
            chk("bp_hold_data", 32'(dout[2]), 32'hA5);
            chk("bp_overrun", 32'(ovr[2]), 32'(k == W - 1));
        end
        chk("bp_lsb_no_overrun", 32'(ovr[0]), 32'd0);
        chk("bp_lsb_hold", 32'(dout[0]), 32'hA5);
        drive(1'b0, 1'b0, 1'b0);
        chk("bp_overrun_pulse_end", 32'(ovr[2]), 32'd0);
        chk("bp_still_valid", 32'(dv[2]), 32'd1);
        data_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            chk($sformatf("bp_released[%0d]", i), 32'(dv[i]), 32'd0);

        // Continuous: new word loads in the same cycle the held one drains.
        data_ready = 1'b0;
        push(3'b111, 8'h3C, 8'h3C, 8'h3C);
        push(3'b100, 8'h00, 8'h00, 8'h5A);
        send_word(8'h3C, 1'b1, 0);
        for (int k = 0; k < W - 1; k++) drive(1'b1, w5a[k], 1'b0);
        data_ready = 1'b1;
        drive(1'b1, w5a[W-1], 1'b0);
        chk("cont_reload_valid", 32'(dv[2]), 32'd1);
        chk("cont_reload_data", 32'(dout[2]), 32'h5A);
        chk("cont_reload_overrun", 32'(ovr[2]), 32'd0);
        chk("cont_lsb_drained", 32'(dv[0]), 32'd0);
        drive(1'b0, 1'b0, 1'b0);
        chk("cont_drained", 32'(dv[2]), 32'd0);

        // Resync on the fifth bit of a word.
        push(3'b111, 8'hF0, 8'h0F, 8'hF0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk("resync_partial_count", 32'(bc[0]), 32'd4);
        for (int k = 0; k < W; k++) begin
            drive(1'b1, wf0[k], k == 0);
            for (int i = 0; i < 3; i++)
                chk($sformatf("resync_fe_b%0d[%0d]", k, i), 32'(fe[i]), 32'(k == 0));
            if (k == 0) chk("resync_count", 32'(bc[1]), 32'd1);
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("resync_valid[%0d]", i), 32'(dv[i]), 32'd1);
        drive(1'b0, 1'b0, 1'b0);

        // Reset mid-word with a held word pending, then a clean framed word.
        data_ready = 1'b0;
        send_word(8'h4D, 1'b1, 0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1);
        chk_reset_state();
        reset = 1'b0;
        data_ready = 1'b1;
        push(3'b111, 8'h81, 8'h81, 8'h81);
        send_word(8'h81, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("post_rst_valid[%0d]", i), 32'(dv[i]), 32'd1);
            chk($sformatf("post_rst_fe[%0d]", i), 32'(fe[i]), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        chk("sb_left_lsb", 32'(q0.size()), 32'd0);
        chk("sb_left_msb", 32'(q1.size()), 32'd0);
        chk("sb_left_cont", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
